// File: rtl/nco_pkg.sv
// Shared widths, config layout and helpers for the multi-voice NCO.
// The config word is {wave, oct, inc} with inc in the LSBs.
package nco_pkg;

    localparam int unsigned ACC_WIDTH   = 18;
    localparam int unsigned OCT_BITS    = 3;
    localparam int unsigned WAVE_BITS   = 7;
    localparam int unsigned SAMPLE_BITS = 8;

    localparam int unsigned CFG_WIDTH  = ACC_WIDTH + OCT_BITS + WAVE_BITS;
    localparam int unsigned ADDR_WIDTH = WAVE_BITS + SAMPLE_BITS;

    // Field offsets inside the packed config word
    localparam int unsigned INC_LSB  = 0;
    localparam int unsigned OCT_LSB  = ACC_WIDTH;
    localparam int unsigned WAVE_LSB = ACC_WIDTH + OCT_BITS;

    // Octave code that freezes the sample address
    localparam logic [OCT_BITS-1:0] OCT_FREEZE = '1;

    typedef struct packed {
        logic [WAVE_BITS-1:0] wave;
        logic [OCT_BITS-1:0]  oct;
        logic [ACC_WIDTH-1:0] inc;
    } voice_cfg_t;

    // Voice index width; at least one bit even for a single voice
    function automatic int unsigned vw_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nco_voice_step.sv
// Combinational next-state for one NCO voice.
// Ports:
//   i_acc / i_addr        current accumulator and sample address
//   i_cfg                 packed {wave, oct, inc} config used for this service
//   i_sync                effective hard sync for this service
//   o_acc_next_c          updated accumulator
//   o_addr_next_c         updated sample address
//   o_address_c           {wave, updated sample address}
//   o_wrap_c              sample address wrapped past zero in this update
module nco_voice_step
    import nco_pkg::*;
(
    input  logic [ACC_WIDTH-1:0]   i_acc,
    input  logic [SAMPLE_BITS-1:0] i_addr,
    input  logic [CFG_WIDTH-1:0]   i_cfg,
    input  logic                   i_sync,
    output logic [ACC_WIDTH-1:0]   o_acc_next_c,
    output logic [SAMPLE_BITS-1:0] o_addr_next_c,
    output logic [ADDR_WIDTH-1:0]  o_address_c,
    output logic                   o_wrap_c
);

    logic [ACC_WIDTH-1:0]   w_inc;
    logic [OCT_BITS-1:0]    w_oct;
    logic [WAVE_BITS-1:0]   w_wave;
    logic [ACC_WIDTH:0]     w_sum;
    logic [SAMPLE_BITS-1:0] w_step;
    logic [SAMPLE_BITS:0]   w_addr_sum;

    assign w_inc  = i_cfg[INC_LSB +: ACC_WIDTH];
    assign w_oct  = i_cfg[OCT_LSB +: OCT_BITS];
    assign w_wave = i_cfg[WAVE_LSB +: WAVE_BITS];

    // Overflow is the carry out of the widened add, not an MSB edge
    assign w_sum = {1'b0, i_acc} + {1'b0, w_inc};

    // Octave step; shifts past the address width contribute nothing
    assign w_step     = (32'(w_oct) < SAMPLE_BITS) ? (SAMPLE_BITS'(1) << w_oct) : '0;
    assign w_addr_sum = {1'b0, i_addr} + {1'b0, w_step};

    // Sync overrides the step; freeze keeps the address but lets acc run
    always_comb begin
        o_acc_next_c  = w_sum[ACC_WIDTH-1:0];
        o_addr_next_c = i_addr;
        o_wrap_c      = 1'b0;
        if (i_sync) begin
            o_acc_next_c  = '0;
            o_addr_next_c = '0;
        end else if (w_sum[ACC_WIDTH] && (w_oct != OCT_FREEZE)) begin
            o_addr_next_c = w_addr_sum[SAMPLE_BITS-1:0];
            o_wrap_c      = w_addr_sum[SAMPLE_BITS];
        end
    end

    assign o_address_c = {w_wave, o_addr_next_c};

endmodule

// File: rtl/nco_multivoice.sv
// Time-multiplexed bank of NUM_VOICES NCOs, one voice serviced per clock.
// Ports:
//   i_clock, i_reset      clock and synchronous active-high reset
//   i_cfg_we/voice/data   single-cycle config write of {wave, oct, inc}
//   i_sync                per-voice hard-sync requests, level sampled
//   o_valid               outputs valid (1 every cycle after reset)
//   o_voice               voice serviced in the previous cycle
//   o_address             wavetable RAM address {wave, sample_addr}
//   o_wrap                that voice's sample address wrapped
module nco_multivoice
    import nco_pkg::*;
#(
    parameter  int unsigned NUM_VOICES = 4,
    localparam int unsigned VW         = vw_of(NUM_VOICES)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_cfg_we,
    input  logic [VW-1:0]         i_cfg_voice,
    input  logic [CFG_WIDTH-1:0]  i_cfg_data,
    input  logic [NUM_VOICES-1:0] i_sync,
    output logic                  o_valid,
    output logic [VW-1:0]         o_voice,
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic                  o_wrap
);

    voice_cfg_t             r_cfg  [NUM_VOICES];
    logic [ACC_WIDTH-1:0]   r_acc  [NUM_VOICES];
    logic [SAMPLE_BITS-1:0] r_addr [NUM_VOICES];
    logic [NUM_VOICES-1:0]  r_pending;
    logic [VW-1:0]          r_slot;

    logic                   w_sync;
    logic                   w_cfg_hit;
    logic                   w_last_slot;
    logic [NUM_VOICES-1:0]  w_slot_mask;
    logic [ACC_WIDTH-1:0]   w_acc_next;
    logic [SAMPLE_BITS-1:0] w_addr_next;
    logic [ADDR_WIDTH-1:0]  w_address;
    logic                   w_wrap;

    // A request arriving in the voice's own slot takes effect immediately
    assign w_sync      = r_pending[r_slot] | i_sync[r_slot];
    assign w_cfg_hit   = i_cfg_we && (32'(i_cfg_voice) < NUM_VOICES);
    assign w_last_slot = (32'(r_slot) == NUM_VOICES - 1);
    assign w_slot_mask = NUM_VOICES'(1) << r_slot;

    nco_voice_step u_step (
        .i_acc         (r_acc[r_slot]),
        .i_addr        (r_addr[r_slot]),
        .i_cfg         (r_cfg[r_slot]),
        .i_sync        (w_sync),
        .o_acc_next_c  (w_acc_next),
        .o_addr_next_c (w_addr_next),
        .o_address_c   (w_address),
        .o_wrap_c      (w_wrap)
    );

    // Voice state, slot counter and registered outputs.
    // The service reads the old cfg; a same-cycle write lands afterwards.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                r_cfg[v]  <= '0;
                r_acc[v]  <= '0;
                r_addr[v] <= '0;
            end
            r_pending <= '0;
            r_slot    <= '0;
            o_valid   <= 1'b0;
            o_voice   <= '0;
            o_address <= '0;
            o_wrap    <= 1'b0;
        end else begin
            r_acc[r_slot]  <= w_acc_next;
            r_addr[r_slot] <= w_addr_next;
            if (w_cfg_hit) begin
                r_cfg[i_cfg_voice] <= voice_cfg_t'(i_cfg_data);
            end
            // The serviced voice consumes its pending request
            r_pending <= (r_pending | i_sync) & ~w_slot_mask;
            r_slot    <= w_last_slot ? '0 : r_slot + VW'(1);
            o_valid   <= 1'b1;
            o_voice   <= r_slot;
            o_address <= w_address;
            o_wrap    <= w_wrap;
        end
    end

endmodule
